// File: rtl/stack_arbiter.sv
// stack_arbiter
// Shares one LIFO stack between two requesters. Each requester sends push or
// pop commands over a req/ack handshake. Ties are resolved round-robin. The
// block tracks stack occupancy itself. Push-when-full and pop-when-empty are
// answered with ack+err and never reach the stack. The block also sequences
// the stack's command strobe and its one-cycle-late pop readback.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   reqN/opN/wdataN       requester N command (op: 1 = push, 0 = pop), N = 0/1
//   ackN/errN/rdataN      one-cycle completion pulse, reject flag, pop result
//   flush                 empty the stack (wins over requests when idle)
//   stk_en/stk_push       one-cycle stack command strobe and its type
//   stk_wdata/stk_rdata   data to / from the stack (rdata valid one cycle
//                         after a pop strobe)
//   stk_clr               one-cycle stack clear strobe
//   level                 current occupancy, 0..DEPTH
//   busy                  high whenever the controller is not idle
module stack_arbiter #(
  parameter int DW    = 16,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   op0,
  input  logic [DW-1:0]          wdata0,
  output logic                   ack0,
  output logic                   err0,
  output logic [DW-1:0]          rdata0,
  input  logic                   req1,
  input  logic                   op1,
  input  logic [DW-1:0]          wdata1,
  output logic                   ack1,
  output logic                   err1,
  output logic [DW-1:0]          rdata1,
  input  logic                   flush,
  output logic                   stk_en,
  output logic                   stk_push,
  output logic [DW-1:0]          stk_wdata,
  output logic                   stk_clr,
  input  logic [DW-1:0]          stk_rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    CLR   = 3'd4
  } state_t;

  state_t          state_r, state_nx;
  logic            last_r, last_nx;     // last granted requester
  logic            win_r, win_nx;       // requester owning the current op
  logic            op_r, op_nx;         // latched op of the current winner
  logic [LW-1:0]   level_r, level_nx;

  logic            ack0_r, ack0_nx;
  logic            ack1_r, ack1_nx;
  logic            err0_r, err0_nx;
  logic            err1_r, err1_nx;
  logic [DW-1:0]   rdata0_r, rdata0_nx;
  logic [DW-1:0]   rdata1_r, rdata1_nx;
  logic            stk_en_r, stk_en_nx;
  logic            stk_push_r, stk_push_nx;
  logic [DW-1:0]   stk_wdata_r, stk_wdata_nx;
  logic            stk_clr_r, stk_clr_nx;
  logic            busy_r, busy_nx;

  // Arbitration results for the current IDLE cycle
  logic            win_s;
  logic            op_s;
  logic [DW-1:0]   wdata_s;
  logic            bad_s;

  // Next-state, arbitration and next-output logic. Outputs are computed one
  // cycle ahead so that every port comes straight from a flop.
  always_comb begin
    state_nx     = state_r;
    last_nx      = last_r;
    win_nx       = win_r;
    op_nx        = op_r;
    level_nx     = level_r;
    ack0_nx      = 1'b0;
    ack1_nx      = 1'b0;
    err0_nx      = 1'b0;
    err1_nx      = 1'b0;
    rdata0_nx    = rdata0_r;
    rdata1_nx    = rdata1_r;
    stk_en_nx    = 1'b0;
    stk_push_nx  = 1'b0;
    stk_wdata_nx = stk_wdata_r;
    stk_clr_nx   = 1'b0;

    // Single requester wins outright; on a tie the one not granted last wins.
    if (req0 && req1) begin
      win_s = ~last_r;
    end else begin
      win_s = req1;
    end
    if (win_s) begin
      op_s    = op1;
      wdata_s = wdata1;
    end else begin
      op_s    = op0;
      wdata_s = wdata0;
    end
    if (op_s) begin
      bad_s = (level_r == LVL_FULL);
    end else begin
      bad_s = (level_r == LVL_ZERO);
    end

    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nx   = CLR;
          stk_clr_nx = 1'b1;
        end else if (req0 || req1) begin
          last_nx = win_s;
          win_nx  = win_s;
          op_nx   = op_s;
          if (bad_s) begin
            // Rejected: answer straight away, stack untouched.
            state_nx = RESP;
            ack0_nx  = ~win_s;
            err0_nx  = ~win_s;
            ack1_nx  = win_s;
            err1_nx  = win_s;
          end else begin
            state_nx     = ISSUE;
            stk_en_nx    = 1'b1;
            stk_push_nx  = op_s;
            stk_wdata_nx = wdata_s;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (op_r) begin
          level_nx = level_r + LVL_ONE;
          state_nx = RESP;
          ack0_nx  = ~win_r;
          ack1_nx  = win_r;
        end else begin
          level_nx = level_r - LVL_ONE;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // Pop data arrives the cycle after the strobe.
        if (win_r) begin
          rdata1_nx = stk_rdata;
        end else begin
          rdata0_nx = stk_rdata;
        end
        state_nx = RESP;
        ack0_nx  = ~win_r;
        ack1_nx  = win_r;
      end
      RESP: begin
        state_nx = IDLE;
      end
      CLR: begin
        level_nx = LVL_ZERO;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State, bookkeeping and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      win_r       <= 1'b0;
      op_r        <= 1'b0;
      level_r     <= LVL_ZERO;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      err0_r      <= 1'b0;
      err1_r      <= 1'b0;
      rdata0_r    <= {DW{1'b0}};
      rdata1_r    <= {DW{1'b0}};
      stk_en_r    <= 1'b0;
      stk_push_r  <= 1'b0;
      stk_wdata_r <= {DW{1'b0}};
      stk_clr_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      last_r      <= last_nx;
      win_r       <= win_nx;
      op_r        <= op_nx;
      level_r     <= level_nx;
      ack0_r      <= ack0_nx;
      ack1_r      <= ack1_nx;
      err0_r      <= err0_nx;
      err1_r      <= err1_nx;
      rdata0_r    <= rdata0_nx;
      rdata1_r    <= rdata1_nx;
      stk_en_r    <= stk_en_nx;
      stk_push_r  <= stk_push_nx;
      stk_wdata_r <= stk_wdata_nx;
      stk_clr_r   <= stk_clr_nx;
      busy_r      <= busy_nx;
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign err0      = err0_r;
  assign err1      = err1_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign stk_en    = stk_en_r;
  assign stk_push  = stk_push_r;
  assign stk_wdata = stk_wdata_r;
  assign stk_clr   = stk_clr_r;
  assign level     = level_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter
// Self-checking bench for stack_arbiter. A transaction-level reference model
// (queue-based stack, round-robin pointer, fixed latency table per operation)
// predicts every output for every cycle. A behavioural stack device sits on
// the stack port. Directed scenarios are followed by randomized traffic.
module tb_stack_arbiter;

  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] stk_rdata = '0;
  logic          ack0, ack1, err0, err1, stk_en, stk_push, stk_clr, busy;
  logic [DW-1:0] rdata0, rdata1, stk_wdata;
  logic [6:0]    level;

  stack_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .flush(flush), .stk_en(stk_en), .stk_push(stk_push), .stk_wdata(stk_wdata),
    .stk_clr(stk_clr), .stk_rdata(stk_rdata), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs for one future cycle
  typedef struct packed {
    logic        ack0, ack1, err0, err1, en, push, clr, busy;
    logic [15:0] wd;
    logic        lu;
    logic [6:0]  lv;
    logic        r0u, r1u;
    logic [15:0] r0v, r1v;
  } slot_t;

  slot_t       sl [8];
  logic [15:0] q [$];          // reference stack contents
  logic [15:0] mem [$];        // behavioural stack device contents
  bit          last;
  int          free_at;
  int          exp_level;
  logic [15:0] exp_rd0, exp_rd1;

  bit          pend [2];
  bit          opv [2];
  logic [15:0] wdv [2];
  int          ackc [2];
  int          refill [2];
  bit          flush_pend;
  bit          rand_mode;
  int          push_pct;
  int          flush_div;

  // Behavioural stack device: pop data shows up the cycle after the strobe,
  // random garbage on every other cycle.
  logic        d_en, d_push, d_clr;
  logic [15:0] d_wd;
  initial begin
    forever begin
      @(negedge clk);
      d_en = stk_en; d_push = stk_push; d_wd = stk_wdata; d_clr = stk_clr;
      @(posedge clk);
      #1;
      stk_rdata = 16'($urandom);
      if (reset) mem.delete();
      else if (d_clr) mem.delete();
      else if (d_en && d_push) mem.push_back(d_wd);
      else if (d_en && !d_push && mem.size() > 0) stk_rdata = mem.pop_back();
    end
  end

  task automatic issue(input int i, input bit o, input logic [15:0] d);
    pend[i] = 1'b1; opv[i] = o; wdv[i] = d; ackc[i] = -1;
  endtask

  // Model one IDLE cycle n: decide what happens and schedule its outputs.
  task automatic arbitrate(input int n);
    int w;
    logic [15:0] v;
    int s1, s2, s3;
    s1 = (n + 1) % 8; s2 = (n + 2) % 8; s3 = (n + 3) % 8;
    if (flush) begin
      sl[s1].clr = 1'b1; sl[s1].busy = 1'b1;
      sl[s2].lu = 1'b1; sl[s2].lv = 7'd0;
      q.delete();
      free_at = n + 2;
    end else if (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) w = last ? 0 : 1;
      else w = pend[1] ? 1 : 0;
      last = (w == 1);
      if ((opv[w] && q.size() == DEPTH) || (!opv[w] && q.size() == 0)) begin
        sl[s1].busy = 1'b1;
        if (w == 0) begin sl[s1].ack0 = 1'b1; sl[s1].err0 = 1'b1; end
        else begin sl[s1].ack1 = 1'b1; sl[s1].err1 = 1'b1; end
        ackc[w] = n + 1; free_at = n + 2;
      end else if (opv[w]) begin
        sl[s1].en = 1'b1; sl[s1].push = 1'b1; sl[s1].wd = wdv[w]; sl[s1].busy = 1'b1;
        q.push_back(wdv[w]);
        sl[s2].busy = 1'b1; sl[s2].lu = 1'b1; sl[s2].lv = 7'(q.size());
        if (w == 0) sl[s2].ack0 = 1'b1; else sl[s2].ack1 = 1'b1;
        ackc[w] = n + 2; free_at = n + 3;
      end else begin
        v = q.pop_back();
        sl[s1].en = 1'b1; sl[s1].push = 1'b0; sl[s1].busy = 1'b1;
        sl[s2].busy = 1'b1; sl[s2].lu = 1'b1; sl[s2].lv = 7'(q.size());
        sl[s3].busy = 1'b1;
        if (w == 0) begin sl[s3].ack0 = 1'b1; sl[s3].r0u = 1'b1; sl[s3].r0v = v; end
        else begin sl[s3].ack1 = 1'b1; sl[s3].r1u = 1'b1; sl[s3].r1v = v; end
        ackc[w] = n + 3; free_at = n + 4;
      end
    end
  endtask

  // One cycle: check this cycle's outputs, update requesters, drive inputs.
  task automatic step();
    int n, s;
    @(negedge clk);
    n = cyc; s = n % 8;
    if (sl[s].lu)  exp_level = int'(sl[s].lv);
    if (sl[s].r0u) exp_rd0 = sl[s].r0v;
    if (sl[s].r1u) exp_rd1 = sl[s].r1v;
    check_eq("ack0", ack0, sl[s].ack0);
    check_eq("ack1", ack1, sl[s].ack1);
    check_eq("err0", err0, sl[s].err0);
    check_eq("err1", err1, sl[s].err1);
    check_eq("stk_en", stk_en, sl[s].en);
    check_eq("stk_clr", stk_clr, sl[s].clr);
    check_eq("busy", busy, sl[s].busy);
    check_eq("level", level, exp_level);
    check_eq("rdata0", rdata0, exp_rd0);
    check_eq("rdata1", rdata1, exp_rd1);
    if (sl[s].en) begin
      check_eq("stk_push", stk_push, sl[s].push);
      if (sl[s].push) check_eq("stk_wdata", stk_wdata, sl[s].wd);
    end
    sl[s] = '0;
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && ackc[i] == n) begin
        pend[i] = 1'b0;
        if (refill[i] > 0) begin
          refill[i]--;
          issue(i, 1'b1, 16'($urandom));
        end
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0)
          issue(i, $urandom_range(0, 99) < push_pct, 16'($urandom));
      if (n >= free_at && $urandom_range(0, flush_div - 1) == 0) flush_pend = 1'b1;
    end
    if (flush_pend && n >= free_at) begin
      flush = 1'b1; flush_pend = 1'b0;
    end else begin
      flush = 1'b0;
    end
    req0 = pend[0]; op0 = opv[0]; wdata0 = wdv[0];
    req1 = pend[1]; op1 = opv[1]; wdata1 = wdv[1];
    if (n >= free_at) arbitrate(n);
  endtask

  task automatic run_until_idle(input int maxc);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((pend[0] || pend[1] || flush_pend || cyc + 1 < free_at) && k < maxc);
    if (pend[0] || pend[1] || flush_pend || cyc + 1 < free_at)
      check_eq("timeout", 32'd1, 32'd0);
  endtask

  // Assert reset right now, check all outputs cleared at once, restart model.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_ack0", ack0, 0);
    check_eq("rst_ack1", ack1, 0);
    check_eq("rst_err0", err0, 0);
    check_eq("rst_err1", err1, 0);
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_rdata1", rdata1, 0);
    check_eq("rst_stk_en", stk_en, 0);
    check_eq("rst_stk_push", stk_push, 0);
    check_eq("rst_stk_wdata", stk_wdata, 0);
    check_eq("rst_stk_clr", stk_clr, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    for (int k = 0; k < 8; k++) sl[k] = '0;
    q.delete();
    last = 1'b1;
    exp_level = 0; exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; refill[i] = 0; ackc[i] = -1; end
    flush_pend = 1'b0; flush = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    free_at = cyc;
  endtask

  initial begin
    rand_mode = 1'b0; push_pct = 50; flush_div = 60;
    @(negedge clk);
    do_reset();

    // Single push from requester 0
    issue(0, 1'b1, 16'hA5A5);
    run_until_idle(20);
    check_eq("t1_level", level, 1);

    // Push then pop from the other requester
    flush_pend = 1'b1;
    run_until_idle(20);
    issue(0, 1'b1, 16'h1234);
    run_until_idle(20);
    issue(1, 1'b0, 16'h0000);
    run_until_idle(20);
    check_eq("t2_rdata1", rdata1, 16'h1234);
    check_eq("t2_rdata0_held", rdata0, 16'h0000);
    check_eq("t2_level", level, 0);

    // Both requesters pushing for four grants: order 0,1,0,1
    issue(0, 1'b1, 16'h0101); refill[0] = 1;
    issue(1, 1'b1, 16'h0202); refill[1] = 1;
    run_until_idle(40);
    check_eq("t3_level", level, 4);

    // Pop when empty, then fill to DEPTH and overflow
    flush_pend = 1'b1;
    run_until_idle(20);
    issue(0, 1'b0, 16'h0000);
    run_until_idle(20);
    check_eq("t4_empty_level", level, 0);
    issue(0, 1'b1, 16'h5000); refill[0] = DEPTH - 1;
    run_until_idle(400);
    check_eq("t4_full_level", level, DEPTH);
    issue(1, 1'b1, 16'hFFFF);
    run_until_idle(20);
    check_eq("t4_ovf_level", level, DEPTH);

    // Flush together with a request at level 5
    flush_pend = 1'b1;
    run_until_idle(20);
    issue(1, 1'b1, 16'h0005); refill[1] = 4;
    run_until_idle(60);
    check_eq("t5_level5", level, 5);
    flush_pend = 1'b1;
    issue(0, 1'b1, 16'hBEEF);
    run_until_idle(20);
    check_eq("t5_level", level, 1);

    // Reset while a pop waits for stack data, then a tie goes to requester 0
    issue(1, 1'b0, 16'h0000);
    step(); step(); step();
    do_reset();
    issue(0, 1'b1, 16'hC0C0);
    issue(1, 1'b1, 16'hC1C1);
    run_until_idle(20);
    check_eq("t6_level", level, 2);

    // Randomized traffic: push-heavy first so the full boundary is reached
    rand_mode = 1'b1; push_pct = 85; flush_div = 400;
    repeat (1500) step();
    push_pct = 30; flush_div = 60;
    repeat (1500) step();
    rand_mode = 1'b0;
    run_until_idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
